tile_index_scheduler: RTL and testbench
=======================================

# tile_index_scheduler

Hands out output-tile coordinates (row, col) of a blocked matrix product to the processing units. Each grant goes to one requesting processor, chosen round-robin. The block counts per-tile completions and raises a one-cycle done when every tile has been both issued and finished. It sits between the main controller, which starts it, and the processor array, which requests and completes tiles.

## Interface
Parameters:
- NUMBER_OF_PROCESSORS, 4, number of requesters (≥2)
- INDEX_WIDTH, 8, width of tile row/col indexes and tile-count inputs

Ports:
- clk  input  1  single clock, all logic on rising edge
- reset  input  1  synchronous, active-high
- i_Start  input  1  start pulse from main controller
- i_Row_Tiles  input  INDEX_WIDTH  tile rows in the result, sampled with i_Start
- i_Col_Tiles  input  INDEX_WIDTH  tile columns in the result, sampled with i_Start
- i_Index_Request  input  NUMBER_OF_PROCESSORS  per-processor request for a new tile (level)
- i_Result_Done  input  NUMBER_OF_PROCESSORS  per-processor one-cycle tile-finished pulse
- o_Index_Grant  output  NUMBER_OF_PROCESSORS  one-hot grant, one cycle wide
- o_Row_Index  output  INDEX_WIDTH  tile row for the current grant
- o_Col_Index  output  INDEX_WIDTH  tile column for the current grant
- o_Busy  output  1  high in DISPATCH and DRAIN
- o_Done  output  1  one-cycle pulse when the job is complete

## Operation
- Reset values:
  - state IDLE.
  - All outputs 0.
  - Issued, completed and tile counters 0.
  - Round-robin pointer 0.
- Total = i_Row_Tiles × i_Col_Tiles. Latched at start into a 2·INDEX_WIDTH register. Issued and completed counters have the same width.
- IDLE:
  - i_Start with both dims nonzero: latch dims, set row=col=0, clear counters, go DISPATCH.
  - i_Start with either dim zero: go DONE.
  - i_Result_Done and i_Index_Request are ignored.
- DISPATCH:
  - Eligible set = i_Index_Request AND NOT(last-cycle o_Index_Grant). The mask prevents a double grant to a requester that has not yet dropped its request.
  - If the eligible set is nonempty, choose the first eligible index at or after the pointer, wrapping modulo N.
  - Register o_Index_Grant one-hot, with o_Row_Index/o_Col_Index = current (row, col).
  - On each grant:
    - pointer ← winner+1 mod N;
    - issued++;
    - col++; when col == Col_Tiles−1, col ← 0 and row++.
  - At most one grant per cycle.
  - When the grant that makes issued == total is registered, go DRAIN.
- Completion counting, in DISPATCH and DRAIN: completed += popcount(i_Result_Done) each cycle. Multiple simultaneous pulses all count. Increments beyond total are discarded; completed saturates at total.
- DRAIN:
  - No grants; requests ignored.
  - When completed == total (including this cycle's pulses), go DONE.
- DONE: o_Done=1 for exactly one cycle, then IDLE.
- i_Start outside IDLE is ignored.
- reset at any time: return to IDLE and restore all reset values at that edge. A grant issued in the previous cycle is not repeated.

## Timing
- i_Start sampled at edge E0 → o_Busy=1 after E0.
- Request high during DISPATCH at edge En → grant, row and col valid for the one cycle after En.
- o_Row_Index/o_Col_Index hold their last value between grants. They are only meaningful while o_Index_Grant is nonzero.
- Requester contract: drop the request in the cycle it sees its grant. If held longer, the requester is re-eligible one cycle later and receives another tile.
- Final Result_Done sampled at edge Ed → state DONE after Ed, o_Done high for the following cycle, IDLE after the next edge. o_Busy falls in the same cycle o_Done rises.
- Zero-dim start at E0 → o_Done high for the cycle after E0, o_Busy never asserted.
- Done pulse and final grant on the same edge: both take effect; the DRAIN exit check uses the updated counts.

## Test plan
- 2×2 job, all 4 processors requesting continuously with the one-cycle drop:
  - grants go 0,1,2,3 with (row,col) = (0,0),(0,1),(1,0),(1,1) on consecutive-eligible cycles;
  - then DRAIN; four done pulses → single o_Done; o_Busy falls.
- 3×3 job, only processors 0 and 2 requesting:
  - grants alternate 0,2,0,2,…, nine in total, last (2,2);
  - a request from 1 raised mid-job is served before 0 when the pointer is 1.
- Simultaneous completions: 1×4 job; after the issue phase, i_Result_Done=4'b1111 in one cycle → completed=4, o_Done the next cycle. Extra done pulses before that are saturated, with no early done.
- i_Row_Tiles=0, i_Col_Tiles=5 start → o_Done one cycle later, no grants, o_Busy stays 0.
- reset asserted after 2 of 4 grants → next cycle grants=0, o_Busy=0, state IDLE. A new 2×2 start restarts at (0,0) with pointer 0.
- i_Start pulsed during DISPATCH with different dims → ignored: tile count and index sequence unchanged.

Source files
------------

// File: rtl/tile_index_scheduler_if.sv
// rtl/tile_index_scheduler_if.sv - controller/processor-array bundle for the tile index scheduler
interface tile_index_scheduler_if #(
   parameter int NUMBER_OF_PROCESSORS = 4,
   parameter int INDEX_WIDTH          = 8
);
   logic                            i_Start;
   logic [INDEX_WIDTH-1:0]          i_Row_Tiles;
   logic [INDEX_WIDTH-1:0]          i_Col_Tiles;
   logic [NUMBER_OF_PROCESSORS-1:0] i_Index_Request;
   logic [NUMBER_OF_PROCESSORS-1:0] i_Result_Done;
   logic [NUMBER_OF_PROCESSORS-1:0] o_Index_Grant;
   logic [INDEX_WIDTH-1:0]          o_Row_Index;
   logic [INDEX_WIDTH-1:0]          o_Col_Index;
   logic                            o_Busy;
   logic                            o_Done;

   modport master (
      output i_Start, i_Row_Tiles, i_Col_Tiles, i_Index_Request, i_Result_Done,
      input  o_Index_Grant, o_Row_Index, o_Col_Index, o_Busy, o_Done
   );

   modport slave (
      input  i_Start, i_Row_Tiles, i_Col_Tiles, i_Index_Request, i_Result_Done,
      output o_Index_Grant, o_Row_Index, o_Col_Index, o_Busy, o_Done
   );
endinterface

// File: rtl/tile_index_scheduler.sv
// rtl/tile_index_scheduler.sv - round-robin tile (row, col) dispatcher with completion tracking
module tile_index_scheduler #(
   parameter int NUMBER_OF_PROCESSORS = 4,
   parameter int INDEX_WIDTH          = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   tile_index_scheduler_if.slave bus
);
   localparam int NP = NUMBER_OF_PROCESSORS;
   localparam int IW = INDEX_WIDTH;
   localparam int CW = 2 * INDEX_WIDTH;
   localparam int PW = $clog2(NUMBER_OF_PROCESSORS);

   typedef enum logic [1:0] {S_IDLE, S_DISPATCH, S_DRAIN, S_DONE} state_t;

   state_t          state_q;
   logic [IW-1:0]   col_tiles_q;
   logic [CW-1:0]   total_q, issued_q, completed_q;
   logic [IW-1:0]   row_q, col_q;
   logic [PW-1:0]   ptr_q;
   logic [NP-1:0]   grant_q;
   logic [IW-1:0]   row_idx_q, col_idx_q;
   logic            busy_q, done_q;

   logic [NP-1:0]   eligible;
   logic            win_found;
   logic [PW-1:0]   win_idx, scan_idx;
   logic [CW-1:0]   done_count, completed_d;
   logic [CW:0]     comp_sum;

   // A requester granted last cycle is masked so a late-dropped request cannot win twice.
   always_comb begin
      eligible  = bus.i_Index_Request & ~grant_q;
      win_found = 1'b0;
      win_idx   = '0;
      scan_idx  = '0;
      for (int k = 0; k < NP; k++) begin
         scan_idx = PW'((int'(ptr_q) + k) % NP);
         if (!win_found && eligible[scan_idx]) begin
            win_found = 1'b1;
            win_idx   = scan_idx;
         end
      end
   end

   always_comb begin
      done_count = '0;
      for (int p = 0; p < NP; p++) begin
         done_count = done_count + CW'(bus.i_Result_Done[p]);
      end
      comp_sum    = {1'b0, completed_q} + {1'b0, done_count};
      completed_d = (comp_sum >= {1'b0, total_q}) ? total_q : comp_sum[CW-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         col_tiles_q <= '0;
         total_q     <= '0;
         issued_q    <= '0;
         completed_q <= '0;
         row_q       <= '0;
         col_q       <= '0;
         ptr_q       <= '0;
         grant_q     <= '0;
         row_idx_q   <= '0;
         col_idx_q   <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         grant_q <= '0;
         done_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.i_Start) begin
                  if ((bus.i_Row_Tiles != '0) && (bus.i_Col_Tiles != '0)) begin
                     col_tiles_q <= bus.i_Col_Tiles;
                     total_q     <= CW'(bus.i_Row_Tiles) * CW'(bus.i_Col_Tiles);
                     row_q       <= '0;
                     col_q       <= '0;
                     issued_q    <= '0;
                     completed_q <= '0;
                     busy_q      <= 1'b1;
                     state_q     <= S_DISPATCH;
                  end else begin
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end
               end
            end
            S_DISPATCH: begin
               completed_q <= completed_d;
               if (win_found) begin
                  grant_q   <= NP'(1) << win_idx;
                  row_idx_q <= row_q;
                  col_idx_q <= col_q;
                  ptr_q     <= PW'((int'(win_idx) + 1) % NP);
                  issued_q  <= issued_q + CW'(1);
                  if (col_q == col_tiles_q - IW'(1)) begin
                     col_q <= '0;
                     row_q <= row_q + IW'(1);
                  end else begin
                     col_q <= col_q + IW'(1);
                  end
                  if (issued_q + CW'(1) == total_q) begin
                     state_q <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               completed_q <= completed_d;
               if (completed_d == total_q) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.o_Index_Grant = grant_q;
   assign bus.o_Row_Index   = row_idx_q;
   assign bus.o_Col_Index   = col_idx_q;
   assign bus.o_Busy        = busy_q;
   assign bus.o_Done        = done_q;
endmodule

// File: tb/tb_tile_index_scheduler.sv
// tb/tb_tile_index_scheduler.sv - scoreboard bench for tile_index_scheduler
module tb_tile_index_scheduler;
   localparam int NP = 4;
   localparam int IW = 8;

   typedef struct packed {
      logic          done;
      logic [NP-1:0] grant;
      logic [IW-1:0] row;
      logic [IW-1:0] col;
   } ev_t;

   logic clk = 1'b0;
   logic reset;
   tile_index_scheduler_if #(.NUMBER_OF_PROCESSORS(NP), .INDEX_WIDTH(IW)) bif ();

   tile_index_scheduler #(.NUMBER_OF_PROCESSORS(NP), .INDEX_WIDTH(IW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bif.slave)
   );

   always #5 clk = ~clk;

   ev_t           exp_q[$];
   ev_t           mon_ev;
   int            n_vec  = 0;
   int            n_fail = 0;
   logic          mon_en = 1'b0;
   logic [NP-1:0] want     = '0;
   logic [NP-1:0] one_shot = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic exp_grant(input int p, input int r, input int c);
      ev_t e;
      e.done = 1'b0; e.grant = NP'(1) << p; e.row = IW'(r); e.col = IW'(c);
      exp_q.push_back(e);
   endtask

   task automatic exp_done();
      ev_t e;
      e = '0; e.done = 1'b1;
      exp_q.push_back(e);
   endtask

   // Requester model: each processor drops its request in the cycle it sees its grant.
   task automatic tick();
      @(posedge clk); #1;
      want = want & ~(one_shot & bif.o_Index_Grant);
      bif.i_Index_Request = want & ~bif.o_Index_Grant;
   endtask

   task automatic set_want(input logic [NP-1:0] v);
      want = v;
      bif.i_Index_Request = want & ~bif.o_Index_Grant;
   endtask

   task automatic start(input int r, input int c);
      bif.i_Row_Tiles = IW'(r);
      bif.i_Col_Tiles = IW'(c);
      bif.i_Start = 1'b1;
      tick();
      bif.i_Start = 1'b0;
   endtask

   task automatic pulse(input logic [NP-1:0] v);
      bif.i_Result_Done = v;
      tick();
      bif.i_Result_Done = '0;
   endtask

   task automatic final_pulse(input string name, input logic [NP-1:0] v);
      pulse(v);
      check({name, "_done_hi"}, 32'(bif.o_Done), 32'd1);
      check({name, "_busy_lo"}, 32'(bif.o_Busy), 32'd0);
      tick();
      check({name, "_done_lo"}, 32'(bif.o_Done), 32'd0);
   endtask

   task automatic wait_empty(input string name, input int limit);
      for (int i = 0; i < limit && exp_q.size() != 0; i++) tick();
      check({name, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
   endtask

   always @(negedge clk) begin
      if (mon_en && (bif.o_Index_Grant != '0 || bif.o_Done)) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL unexpected_output: grant=%b done=%b row=%0d col=%0d, nothing expected at %0t",
                     bif.o_Index_Grant, bif.o_Done, bif.o_Row_Index, bif.o_Col_Index, $time);
         end else begin
            mon_ev = exp_q.pop_front();
            if (mon_ev.done) begin
               check("done_event", 32'({bif.o_Done, bif.o_Index_Grant}), 32'({1'b1, {NP{1'b0}}}));
               check("busy_at_done", 32'(bif.o_Busy), 32'd0);
            end else begin
               check("grant_event", 32'({1'b0, bif.o_Index_Grant, bif.o_Row_Index, bif.o_Col_Index}),
                     32'(mon_ev));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      bif.i_Start = 1'b0;
      bif.i_Row_Tiles = '0;
      bif.i_Col_Tiles = '0;
      bif.i_Index_Request = '0;
      bif.i_Result_Done = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_grant", 32'(bif.o_Index_Grant), 32'd0);
      check("rst_row",   32'(bif.o_Row_Index), 32'd0);
      check("rst_col",   32'(bif.o_Col_Index), 32'd0);
      check("rst_busy",  32'(bif.o_Busy), 32'd0);
      check("rst_done",  32'(bif.o_Done), 32'd0);
      reset  = 1'b0;
      mon_en = 1'b1;

      // 2x2, all four requesting
      exp_grant(0, 0, 0); exp_grant(1, 0, 1); exp_grant(2, 1, 0); exp_grant(3, 1, 1); exp_done();
      want = 4'b1111;
      start(2, 2);
      check("t1_busy", 32'(bif.o_Busy), 32'd1);
      repeat (4) tick();
      set_want('0);
      tick();
      pulse(4'b0001); pulse(4'b0010); pulse(4'b0100);
      final_pulse("t1", 4'b1000);
      wait_empty("t1", 10);

      // 3x3, processors 0 and 2; processor 1 joins once; mid-job start ignored
      exp_grant(0, 0, 0); exp_grant(2, 0, 1); exp_grant(0, 0, 2); exp_grant(2, 1, 0);
      exp_grant(0, 1, 1); exp_grant(1, 1, 2); exp_grant(2, 2, 0); exp_grant(0, 2, 1);
      exp_grant(2, 2, 2); exp_done();
      one_shot = 4'b0010;
      want = 4'b0101;
      start(3, 3);
      tick(); tick();
      bif.i_Row_Tiles = 8'd1; bif.i_Col_Tiles = 8'd1; bif.i_Start = 1'b1;
      tick();
      bif.i_Start = 1'b0;
      tick(); tick();
      set_want(4'b0111);
      repeat (4) tick();
      set_want('0);
      check("t2_busy_drain", 32'(bif.o_Busy), 32'd1);
      repeat (4) pulse(4'b0101);
      check("t2_no_early_done", 32'(bif.o_Done), 32'd0);
      final_pulse("t2", 4'b0001);
      wait_empty("t2", 10);

      // 1x4, simultaneous completions with saturation
      exp_grant(0, 0, 0); exp_grant(0, 0, 1); exp_grant(0, 0, 2); exp_grant(0, 0, 3); exp_done();
      one_shot = '0;
      want = 4'b0001;
      start(1, 4);
      tick();
      pulse(4'b0011);
      repeat (5) tick();
      set_want('0);
      tick();
      check("t3_busy_drain", 32'(bif.o_Busy), 32'd1);
      final_pulse("t3", 4'b1111);
      wait_empty("t3", 10);

      // zero dimension
      exp_done();
      start(0, 5);
      check("t4_done_hi", 32'(bif.o_Done), 32'd1);
      check("t4_busy_lo", 32'(bif.o_Busy), 32'd0);
      tick();
      check("t4_done_lo", 32'(bif.o_Done), 32'd0);
      check("t4_busy_still_lo", 32'(bif.o_Busy), 32'd0);
      wait_empty("t4", 5);

      // reset mid-job, pointer was left at 1 by the 1x4 job
      exp_grant(1, 0, 0); exp_grant(2, 0, 1);
      want = 4'b1111;
      start(2, 2);
      tick(); tick();
      set_want('0);
      reset = 1'b1;
      tick();
      check("t5_rst_grant", 32'(bif.o_Index_Grant), 32'd0);
      check("t5_rst_busy",  32'(bif.o_Busy), 32'd0);
      check("t5_rst_done",  32'(bif.o_Done), 32'd0);
      reset = 1'b0;
      tick();
      check("t5_idle_grant", 32'(bif.o_Index_Grant), 32'd0);
      exp_grant(0, 0, 0); exp_grant(1, 0, 1); exp_grant(2, 1, 0); exp_grant(3, 1, 1); exp_done();
      want = 4'b1111;
      start(2, 2);
      repeat (4) tick();
      set_want('0);
      final_pulse("t5", 4'b1111);
      wait_empty("t5", 10);

      repeat (3) tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
